// File: rtl/typer_pipe.sv
// -----------------------------------------------------------------------------
// typer_pipe
//
// Two-stage (EX, WB) valid/ready pipeline for MIPS R-type instructions. It
// decodes each accepted word, reads two operands from the register file,
// runs the ALU in EX, and holds the result in WB until the sink takes it.
// The register file is written when the sink takes a legal result. The cfg_*
// port preloads registers and is meant to be used while the pipeline is empty.
//
// Optional feature macro: TYPER_FWD_EN
//   defined   : operands are forwarded (EX ALU result > WB result > regfile),
//               so dependent instructions never stall.
//   undefined : a RAW hazard against EX or WB holds in_ready low until the
//               producing instruction has retired and written the regfile.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset (clears pipeline and regfile)
//   in_valid     instruction word is valid
//   in_ready     pipeline accepts the instruction this cycle
//   instruccion  OP[31:26] Rs[25:21] Rt[20:16] Rd[15:11] Shamt[10:6] Fnc[5:0]
//   out_valid    WB stage holds a result
//   out_ready    sink takes the result (retirement = out_valid & out_ready)
//   resultado    ALU result of the WB instruction, 0 when illegal
//   out_rd       destination index of the WB instruction
//   zero_flag    resultado == 0
//   illegal      WB instruction is not a supported R-type
//   cfg_we       preload write enable
//   cfg_addr     preload register index
//   cfg_data     preload data
//   instr_count  number of retired legal instructions (wraps)
// -----------------------------------------------------------------------------
module typer_pipe #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           instruccion,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     resultado,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic                  zero_flag,
    output logic                  illegal,
    input  logic                  cfg_we,
    input  logic [REG_ADDR_W-1:0] cfg_addr,
    input  logic [DATA_W-1:0]     cfg_data,
    output logic [CNT_W-1:0]      instr_count
);

    localparam int unsigned NREGS = 2 ** REG_ADDR_W;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_NOR,
        ALU_SLT
    } alu_op_t;

    // ------------------------------------------------------------------
    // Instruction field extraction and decode
    // ------------------------------------------------------------------
    logic [5:0]            opcode;
    logic [5:0]            fnc;
    logic [REG_ADDR_W-1:0] rs_idx;
    logic [REG_ADDR_W-1:0] rt_idx;
    logic [REG_ADDR_W-1:0] rd_idx;
    logic                  dec_legal;
    alu_op_t               dec_op;

    assign opcode = instruccion[31:26];
    assign fnc    = instruccion[5:0];
    assign rs_idx = instruccion[21 +: REG_ADDR_W];
    assign rt_idx = instruccion[16 +: REG_ADDR_W];
    assign rd_idx = instruccion[11 +: REG_ADDR_W];

    // Shamt has no effect on any supported function.
    logic unused_shamt;
    assign unused_shamt = ^instruccion[10:6];

    always_comb begin
        dec_legal = (opcode == 6'b000000);
        dec_op    = ALU_ADD;
        case (fnc)
            6'b100000: dec_op = ALU_ADD;
            6'b100010: dec_op = ALU_SUB;
            6'b100100: dec_op = ALU_AND;
            6'b100101: dec_op = ALU_OR;
            6'b100111: dec_op = ALU_NOR;
            6'b101010: dec_op = ALU_SLT;
            default:   dec_legal = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Pipeline state
    // ------------------------------------------------------------------
    logic                  ex_valid;
    logic                  ex_legal;
    alu_op_t               ex_op;
    logic [DATA_W-1:0]     ex_a;
    logic [DATA_W-1:0]     ex_b;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic [DATA_W-1:0]     ex_result;

    logic                  wb_valid;
    logic                  wb_illegal;
    logic                  wb_zero;
    logic [DATA_W-1:0]     wb_result;
    logic [REG_ADDR_W-1:0] wb_rd;

    logic [DATA_W-1:0]     regs [NREGS];

    logic                  adv;
    logic                  stall;
    logic                  accept;
    logic                  retire;
    logic                  rf_write;

    assign adv      = !wb_valid || out_ready;
    assign in_ready = rst_n && adv && !stall;
    assign accept   = in_valid && in_ready;
    assign retire   = wb_valid && out_ready;
    assign rf_write = retire && !wb_illegal;

    // ------------------------------------------------------------------
    // Register file read and RAW detection
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] rf_rs;
    logic [DATA_W-1:0] rf_rt;
    logic              ex_produces;
    logic              wb_produces;
    logic              ex_hit_rs;
    logic              ex_hit_rt;
    logic              wb_hit_rs;
    logic              wb_hit_rt;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;

    // Register 0 is never written, so it always reads back as zero.
    assign rf_rs = regs[rs_idx];
    assign rf_rt = regs[rt_idx];

    // Only legal, valid instructions will write the register file, so only
    // those can be producers. Index 0 never creates a dependency.
    assign ex_produces = ex_valid && ex_legal;
    assign wb_produces = wb_valid && !wb_illegal;
    assign ex_hit_rs   = ex_produces && (rs_idx != '0) && (rs_idx == ex_rd);
    assign ex_hit_rt   = ex_produces && (rt_idx != '0) && (rt_idx == ex_rd);
    assign wb_hit_rs   = wb_produces && (rs_idx != '0) && (rs_idx == wb_rd);
    assign wb_hit_rt   = wb_produces && (rt_idx != '0) && (rt_idx == wb_rd);

`ifdef TYPER_FWD_EN
    // The youngest producer (EX) overrides WB, which overrides the regfile.
    assign stall = 1'b0;

    always_comb begin
        op_a = rf_rs;
        if (wb_hit_rs) op_a = wb_result;
        if (ex_hit_rs) op_a = ex_result;
        op_b = rf_rt;
        if (wb_hit_rt) op_b = wb_result;
        if (ex_hit_rt) op_b = ex_result;
    end
`else
    // The regfile is written on the retirement edge, so a consumer waits
    // until its producer has left WB before it can read the new value.
    assign stall = ex_hit_rs || ex_hit_rt || wb_hit_rs || wb_hit_rt;

    always_comb begin
        op_a = rf_rs;
        op_b = rf_rt;
    end
`endif

    // ------------------------------------------------------------------
    // EX stage: ALU (illegal instructions produce zero)
    // ------------------------------------------------------------------
    always_comb begin
        ex_result = '0;
        case (ex_op)
            ALU_ADD: ex_result = ex_a + ex_b;
            ALU_SUB: ex_result = ex_a - ex_b;
            ALU_AND: ex_result = ex_a & ex_b;
            ALU_OR:  ex_result = ex_a | ex_b;
            ALU_NOR: ex_result = ~(ex_a | ex_b);
            ALU_SLT: ex_result = DATA_W'($signed(ex_a) < $signed(ex_b));
            default: ex_result = '0;
        endcase
        if (!ex_legal) ex_result = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid <= 1'b0;
            ex_legal <= 1'b0;
            ex_op    <= ALU_ADD;
            ex_a     <= '0;
            ex_b     <= '0;
            ex_rd    <= '0;
        end else if (adv) begin
            ex_valid <= accept;
            if (accept) begin
                ex_legal <= dec_legal;
                ex_op    <= dec_op;
                ex_a     <= op_a;
                ex_b     <= op_b;
                ex_rd    <= rd_idx;
            end
        end
    end

    // ------------------------------------------------------------------
    // WB stage: holds result until the sink takes it
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid   <= 1'b0;
            wb_illegal <= 1'b0;
            wb_zero    <= 1'b0;
            wb_result  <= '0;
            wb_rd      <= '0;
        end else if (adv) begin
            wb_valid <= ex_valid;
            if (ex_valid) begin
                wb_illegal <= !ex_legal;
                wb_zero    <= (ex_result == '0);
                wb_result  <= ex_result;
                wb_rd      <= ex_rd;
            end else begin
                wb_illegal <= 1'b0;
                wb_zero    <= 1'b0;
                wb_result  <= '0;
                wb_rd      <= '0;
            end
        end
    end

    assign out_valid = wb_valid;
    assign resultado = wb_result;
    assign out_rd    = wb_rd;
    assign zero_flag = wb_zero;
    assign illegal   = wb_illegal;

    // ------------------------------------------------------------------
    // Register file: retirement write has priority over a cfg write to the
    // same index; writes to different indices both land.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[REG_ADDR_W'(i)] <= '0;
            end
        end else begin
            for (int unsigned i = 1; i < NREGS; i++) begin
                if (rf_write && (wb_rd == REG_ADDR_W'(i))) begin
                    regs[REG_ADDR_W'(i)] <= wb_result;
                end else if (cfg_we && (cfg_addr == REG_ADDR_W'(i))) begin
                    regs[REG_ADDR_W'(i)] <= cfg_data;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Retired legal instruction counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_count <= '0;
        end else if (rf_write) begin
            instr_count <= instr_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_typer_pipe.sv
// -----------------------------------------------------------------------------
// tb_typer_pipe
//
// Self-checking bench for typer_pipe. A behavioural model executes every
// accepted instruction in program order against an architectural register
// array; retirements are compared in order against the queued expectations.
// Directed vectors, hand-written corner sequences and a randomized stream are
// applied on top of that model.
// -----------------------------------------------------------------------------
module tb_typer_pipe;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned CW = 32;

    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_NOR = 6'h27;
    localparam logic [5:0] F_SLT = 6'h2A;

`ifdef TYPER_FWD_EN
    localparam int EXP_BUBBLES = 0;
`else
    localparam int EXP_BUBBLES = 2;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [31:0]   instruccion = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] resultado;
    logic [AW-1:0] out_rd;
    logic          zero_flag;
    logic          illegal;
    logic          cfg_we = 1'b0;
    logic [AW-1:0] cfg_addr = '0;
    logic [DW-1:0] cfg_data = '0;
    logic [CW-1:0] instr_count;

    always #5 clk = ~clk;

    typer_pipe #(
        .DATA_W    (DW),
        .REG_ADDR_W(AW),
        .CNT_W     (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .instruccion(instruccion),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .resultado  (resultado),
        .out_rd     (out_rd),
        .zero_flag  (zero_flag),
        .illegal    (illegal),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .instr_count(instr_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired or unexpected event", name);
    endtask

    // ---------------------------------------------------------------------
    // Architectural reference model
    // ---------------------------------------------------------------------
    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;

    logic [31:0] mreg [32];
    exp_t        q[$];
    logic [31:0] mcount = '0;

    function automatic exp_t ref_exec(input logic [31:0] w);
        exp_t        e;
        logic [31:0] a;
        logic [31:0] b;
        a     = mreg[w[25:21]];
        b     = mreg[w[20:16]];
        e.ill = 1'b0;
        e.res = '0;
        case (w[5:0])
            F_ADD:   e.res = a + b;
            F_SUB:   e.res = a - b;
            F_AND:   e.res = a & b;
            F_OR:    e.res = a | b;
            F_NOR:   e.res = ~(a | b);
            F_SLT:   e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: e.ill = 1'b1;
        endcase
        if (w[31:26] != 6'd0) e.ill = 1'b1;
        if (e.ill) e.res = '0;
        e.rd = w[15:11];
        return e;
    endfunction

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < 32; i++) mreg[i] = '0;
        mcount = '0;
    endtask

    initial model_reset();

    // Observes handshakes at the falling edge, i.e. what the next rising
    // edge will commit.
    always @(negedge clk) begin : monitor
        exp_t e;
        bit   pending;
        if (rst_n) begin
            if (cfg_we && cfg_addr != '0) begin
                pending = 1'b0;
                foreach (q[k]) if (!q[k].ill && q[k].rd == cfg_addr) pending = 1'b1;
                if (!pending) mreg[cfg_addr] = cfg_data;
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    fail_now("retire_without_issue");
                end else begin
                    e = q.pop_front();
                    chk("ret_resultado", resultado, e.res);
                    chk("ret_out_rd", out_rd, e.rd);
                    chk("ret_illegal", illegal, e.ill);
                    chk("ret_zero_flag", zero_flag, (e.res == 0));
                    chk("ret_instr_count", instr_count, mcount);
                    if (!e.ill) mcount++;
                end
            end
            if (in_valid && in_ready) begin
                e = ref_exec(instruccion);
                q.push_back(e);
                if (!e.ill && e.rd != 0) mreg[e.rd] = e.res;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Stimulus helpers (inputs change only 1 ns after the rising edge)
    // ---------------------------------------------------------------------
    function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd,
                                        input logic [4:0] sh, input logic [5:0] fn);
        return {op, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [5:0] fn;
        logic [5:0] op;
        case ($urandom_range(0, 6))
            0:       fn = F_ADD;
            1:       fn = F_SUB;
            2:       fn = F_AND;
            3:       fn = F_OR;
            4:       fn = F_NOR;
            5:       fn = F_SLT;
            default: fn = 6'h26;
        endcase
        op = ($urandom_range(0, 15) == 0) ? 6'h23 : 6'h00;
        return enc(op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), fn);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] w, output int waits);
        bit acc;
        in_valid    = 1'b1;
        instruccion = w;
        waits       = 0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                in_valid = 1'b0;
                return;
            end
            waits++;
        end
        in_valid = 1'b0;
        fail_now("issue_timeout");
    endtask

    task automatic drain();
        for (int t = 0; t < 100; t++) begin
            if (q.size() == 0 && !out_valid) return;
            step();
        end
        fail_now("drain_timeout");
    endtask

    task automatic preload(input logic [4:0] a, input logic [31:0] d);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        step();
        cfg_we   = 1'b0;
    endtask

    // Issue into an empty pipeline, check the result one edge after accept.
    task automatic issue_and_check(input string name, input logic [31:0] w,
                                   input logic [31:0] exp_res);
        int waits;
        issue(w, waits);
        step();
        chk({name, "_valid"}, out_valid, 1'b1);
        chk({name, "_res"}, resultado, exp_res);
        drain();
    endtask

    // ---------------------------------------------------------------------
    // Directed vector table
    // ---------------------------------------------------------------------
    typedef struct {
        logic [31:0] w;
        logic [31:0] res;
        logic [4:0]  rd;
        logic        ill;
    } vec_t;

    vec_t tab[13];
    int   waits;

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        // r1 = 2023, r2 = 54 preloaded before the table runs
        tab[0]  = '{32'h00223820,                       32'd2077,       5'd7,  1'b0};
        tab[1]  = '{enc(6'd0, 5'd1, 5'd2, 5'd13, 5'd0, F_ADD), 32'd2077,  5'd13, 1'b0};
        tab[2]  = '{enc(6'd0, 5'd1, 5'd2, 5'd14, 5'd0, F_SUB), 32'd1969,  5'd14, 1'b0};
        tab[3]  = '{enc(6'd0, 5'd1, 5'd2, 5'd15, 5'd0, F_AND), 32'd38,    5'd15, 1'b0};
        tab[4]  = '{enc(6'd0, 5'd1, 5'd2, 5'd16, 5'd0, F_OR),  32'd2039,  5'd16, 1'b0};
        tab[5]  = '{enc(6'd0, 5'd1, 5'd2, 5'd17, 5'd0, F_NOR), 32'hFFFFF808, 5'd17, 1'b0};
        tab[6]  = '{enc(6'd0, 5'd1, 5'd2, 5'd18, 5'd0, F_SLT), 32'd0,     5'd18, 1'b0};
        tab[7]  = '{enc(6'd0, 5'd2, 5'd1, 5'd19, 5'd0, F_SLT), 32'd1,     5'd19, 1'b0};
        tab[8]  = '{enc(6'd0, 5'd2, 5'd1, 5'd20, 5'd0, F_SUB), 32'hFFFFF84F, 5'd20, 1'b0};
        tab[9]  = '{enc(6'd0, 5'd1, 5'd2, 5'd21, 5'd5, F_ADD), 32'd2077,  5'd21, 1'b0};
        tab[10] = '{enc(6'd0, 5'd1, 5'd1, 5'd22, 5'd0, F_ADD), 32'd4046,  5'd22, 1'b0};
        tab[11] = '{enc(6'd0, 5'd20, 5'd1, 5'd18, 5'd0, F_SLT), 32'd1,    5'd18, 1'b0};
        tab[12] = '{enc(6'd0, 5'd1, 5'd20, 5'd19, 5'd0, F_SLT), 32'd0,    5'd19, 1'b0};

        // ---- reset state
        #1 rst_n = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_resultado", resultado, 32'd0);
        chk("rst_out_rd", out_rd, 5'd0);
        chk("rst_zero_flag", zero_flag, 1'b0);
        chk("rst_illegal", illegal, 1'b0);
        chk("rst_instr_count", instr_count, 32'd0);
        repeat (3) step();
        chk("rst_hold_in_ready", in_ready, 1'b0);
        rst_n = 1'b1;
        #1;
        chk("rst_release_in_ready", in_ready, 1'b1);

        preload(5'd1, 32'd2023);
        preload(5'd2, 32'd54);

        // ---- table: latency 2, values, destination
        for (int i = 0; i < 13; i++) begin
            issue(tab[i].w, waits);
            chk($sformatf("tab%0d_waits", i), waits, 0);
            chk($sformatf("tab%0d_ex_only", i), out_valid, 1'b0);
            step();
            chk($sformatf("tab%0d_valid", i), out_valid, 1'b1);
            chk($sformatf("tab%0d_res", i), resultado, tab[i].res);
            chk($sformatf("tab%0d_rd", i), out_rd, tab[i].rd);
            chk($sformatf("tab%0d_ill", i), illegal, tab[i].ill);
            drain();
        end
        chk("tab_count", instr_count, 32'd13);

        // r7 was written by the first table entry
        issue_and_check("r7_readback", enc(6'd0, 5'd7, 5'd0, 5'd8, 5'd0, F_OR), 32'd2077);

        // ---- dependent back-to-back pair
        issue(enc(6'd0, 5'd2, 5'd1, 5'd3, 5'd0, F_SUB), waits);
        issue(enc(6'd0, 5'd3, 5'd0, 5'd4, 5'd0, F_SLT), waits);
        chk("dep_bubbles", waits, EXP_BUBBLES);
        step();
        chk("dep_slt_valid", out_valid, 1'b1);
        chk("dep_slt_res", resultado, 32'd1);
        drain();

        // ---- backpressure with two in flight
        out_ready = 1'b0;
        issue(enc(6'd0, 5'd1, 5'd2, 5'd10, 5'd0, F_AND), waits);
        issue(enc(6'd0, 5'd1, 5'd2, 5'd11, 5'd0, F_OR), waits);
        chk("bp_second_waits", waits, 0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("bp%0d_in_ready", c), in_ready, 1'b0);
            chk($sformatf("bp%0d_valid", c), out_valid, 1'b1);
            chk($sformatf("bp%0d_res", c), resultado, 32'd38);
            chk($sformatf("bp%0d_rd", c), out_rd, 5'd10);
            chk($sformatf("bp%0d_count", c), instr_count, mcount);
            step();
        end
        out_ready = 1'b1;
        drain();

        // ---- illegal words
        begin
            logic [31:0] cnt_before;
            cnt_before = mcount;
            issue(32'h8C223820, waits);
            step();
            chk("ill_op_flag", illegal, 1'b1);
            chk("ill_op_res", resultado, 32'd0);
            chk("ill_op_zero", zero_flag, 1'b1);
            drain();
            issue(32'h00223801, waits);
            step();
            chk("ill_fnc_flag", illegal, 1'b1);
            chk("ill_fnc_res", resultado, 32'd0);
            drain();
            chk("ill_count", instr_count, cnt_before);
            issue_and_check("ill_r7_kept", enc(6'd0, 5'd7, 5'd0, 5'd12, 5'd0, F_OR), 32'd2077);
        end

        // ---- writes to r0 dropped
        issue(enc(6'd0, 5'd1, 5'd2, 5'd0, 5'd0, F_ADD), waits);
        issue(enc(6'd0, 5'd0, 5'd0, 5'd5, 5'd0, F_OR), waits);
        step();
        chk("r0_res", resultado, 32'd0);
        chk("r0_zero", zero_flag, 1'b1);
        chk("r0_rd", out_rd, 5'd5);
        drain();

        // ---- cfg write on the retirement edge: same index, retirement wins
        out_ready = 1'b0;
        issue(enc(6'd0, 5'd1, 5'd2, 5'd23, 5'd0, F_ADD), waits);
        step();
        cfg_we = 1'b1; cfg_addr = 5'd23; cfg_data = 32'd99; out_ready = 1'b1;
        step();
        cfg_we = 1'b0;
        drain();
        issue_and_check("cfg_same", enc(6'd0, 5'd23, 5'd0, 5'd24, 5'd0, F_OR), 32'd2077);

        // ---- different index: both land
        out_ready = 1'b0;
        issue(enc(6'd0, 5'd1, 5'd2, 5'd26, 5'd0, F_ADD), waits);
        step();
        cfg_we = 1'b1; cfg_addr = 5'd25; cfg_data = 32'd77; out_ready = 1'b1;
        step();
        cfg_we = 1'b0;
        drain();
        issue_and_check("cfg_diff_cfg", enc(6'd0, 5'd25, 5'd0, 5'd27, 5'd0, F_OR), 32'd77);
        issue_and_check("cfg_diff_ret", enc(6'd0, 5'd26, 5'd0, 5'd28, 5'd0, F_OR), 32'd2077);

        // ---- randomized stream with hazards and backpressure
        for (int c = 0; c < 400; c++) begin
            in_valid    = ($urandom_range(0, 3) != 0);
            instruccion = rand_instr();
            out_ready   = ($urandom_range(0, 3) != 0);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();
        chk("rand_count", instr_count, mcount);

        // ---- asynchronous reset with two in flight
        issue(enc(6'd0, 5'd1, 5'd2, 5'd5, 5'd0, F_ADD), waits);
        issue(enc(6'd0, 5'd1, 5'd2, 5'd6, 5'd0, F_OR), waits);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_in_ready", in_ready, 1'b0);
        chk("arst_out_valid", out_valid, 1'b0);
        chk("arst_resultado", resultado, 32'd0);
        chk("arst_out_rd", out_rd, 5'd0);
        chk("arst_zero_flag", zero_flag, 1'b0);
        chk("arst_illegal", illegal, 1'b0);
        chk("arst_instr_count", instr_count, 32'd0);
        repeat (2) step();
        rst_n = 1'b1;
        step();
        chk("arst_nothing_retired", instr_count, 32'd0);
        issue_and_check("arst_rf_r1r2", enc(6'd0, 5'd1, 5'd2, 5'd9, 5'd0, F_ADD), 32'd0);
        issue_and_check("arst_rf_r23", enc(6'd0, 5'd23, 5'd0, 5'd8, 5'd0, F_OR), 32'd0);
        chk("final_count", instr_count, mcount);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
